// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fwd_pkg
//  Brief   : Shared types and constants for the EX-stage forwarding / hazard
//            unit (tracking entry layout, select encoding, select width).
//  Revision: 1.0  initial release
// ============================================================================
package fwd_pkg;

  // Widest register address a tracking entry can hold; narrower REG_AW
  // values are zero-extended into the entry.
  localparam int RD_W_MAX = 8;

  // Select value meaning "take the operand from the register file".
  localparam int SEL_RF   = 0;

  // Hard-wired zero register: never forwarded, never stalls.
  localparam int REG_ZERO = 0;

  // One in-flight destination record.
  typedef struct packed {
    logic                valid;
    logic                wb;
    logic                load;
    logic [RD_W_MAX-1:0] rd;
  } fwd_entry_t;

  // Width of one select field: encodes 0 (register file) .. num_fwd.
  function automatic int sel_width(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_port_sel.sv
`default_nettype none
// ============================================================================
//  Module  : fwd_port_sel
//  Brief   : Priority matcher for one EX read port. Finds the youngest
//            tracking entry writing the port's source register and returns
//            its stage index, or flags a load-use hazard when that producer
//            is a load whose data is not yet available.
//  Revision: 1.0  initial release
// ============================================================================
module fwd_port_sel import fwd_pkg::*; #(
  parameter  int REG_AW     = 5,
  parameter  int NUM_FWD    = 2,
  parameter  int LOAD_AVAIL = 2,
  localparam int SW         = sel_width(NUM_FWD)
) (
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic              rs_use_i,
  input  fwd_entry_t        ent_i [NUM_FWD],
  output logic [SW-1:0]     sel_o,
  output logic              hazard_o
);

  logic [RD_W_MAX-1:0] rs_ext;
  logic [NUM_FWD-1:0]  match;
  logic [SW-1:0]       sel_raw;
  logic                haz;

  assign rs_ext = RD_W_MAX'(rs_i);

  // Per-stage match: entry k (index 0 = stage 1) produces this port's operand.
  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      match[k] = ex_valid_i && rs_use_i && ent_i[k].valid && ent_i[k].wb &&
                 (ent_i[k].rd != RD_W_MAX'(REG_ZERO)) && (ent_i[k].rd == rs_ext);
    end
  end

  // Scan oldest to youngest so the youngest match overwrites; a young load
  // that is not yet forwardable blocks any older match (no fallback).
  always_comb begin
    sel_raw = SW'(SEL_RF);
    haz     = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (match[k]) begin
        sel_raw = SW'(k + 1);
        haz     = ent_i[k].load && ((k + 1) < LOAD_AVAIL);
      end
    end
    sel_o    = haz ? SW'(SEL_RF) : sel_raw;
    hazard_o = haz;
  end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module  : fwd_hazard_unit
//  Brief   : EX-stage forwarding select and load-use stall generator. Keeps a
//            shift-register copy of the destination registers of the NUM_FWD
//            instructions beyond EX and derives per-port operand mux selects
//            (youngest producer wins) plus a bubble-inserting stall.
//            Optional macro FWD_PERF_CNT_EN adds saturating stall/forward
//            performance counters (perf_stall_o, perf_fwd_o).
//  Revision: 1.0  initial release
// ============================================================================
module fwd_hazard_unit import fwd_pkg::*; #(
  parameter  int REG_AW     = 5,
  parameter  int NUM_RD     = 2,
  parameter  int NUM_FWD    = 2,
  parameter  int LOAD_AVAIL = 2,
  localparam int SW         = sel_width(NUM_FWD)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     hold_i,
  input  logic                     flush_i,
  input  logic                     ex_valid_i,
  input  logic                     ex_wb_i,
  input  logic                     ex_load_i,
  input  logic [REG_AW-1:0]        ex_rd_i,
  input  logic [NUM_RD*REG_AW-1:0] ex_rs_i,
  input  logic [NUM_RD-1:0]        ex_rs_use_i,
  output logic [NUM_RD*SW-1:0]     fwd_sel_o,
  output logic                     stall_o
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]              perf_stall_o,
  output logic [31:0]              perf_fwd_o
`endif
);

  // Reject configurations the tracking window cannot represent.
  generate
    if (NUM_FWD < 1 || NUM_RD < 1 || LOAD_AVAIL < 1) begin : g_param_err
      $error("fwd_hazard_unit: NUM_FWD, NUM_RD and LOAD_AVAIL must all be >= 1");
    end
    if (REG_AW > RD_W_MAX || REG_AW < 1) begin : g_aw_err
      $error("fwd_hazard_unit: REG_AW out of supported range");
    end
  endgenerate

  fwd_entry_t          t_q [NUM_FWD];
  fwd_entry_t          t_d [NUM_FWD];
  logic [NUM_RD-1:0]   hazard;

  // One priority matcher per read port.
  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      fwd_port_sel #(
        .REG_AW     (REG_AW),
        .NUM_FWD    (NUM_FWD),
        .LOAD_AVAIL (LOAD_AVAIL)
      ) u_port_sel (
        .ex_valid_i (ex_valid_i),
        .rs_i       (ex_rs_i[p*REG_AW +: REG_AW]),
        .rs_use_i   (ex_rs_use_i[p]),
        .ent_i      (t_q),
        .sel_o      (fwd_sel_o[p*SW +: SW]),
        .hazard_o   (hazard[p])
      );
    end
  endgenerate

  // A flush squashes the EX instruction, so it must not request a stall.
  assign stall_o = (|hazard) && !flush_i;

  // Next tracking state: flush beats hold beats shift; a stalled or invalid
  // EX slot enters stage 1 as an all-zero bubble.
  always_comb begin
    for (int k = 0; k < NUM_FWD; k++) begin
      t_d[k] = t_q[k];
    end
    if (flush_i) begin
      for (int k = 0; k < NUM_FWD; k++) begin
        t_d[k].valid = 1'b0;
      end
    end else if (!hold_i) begin
      for (int k = NUM_FWD - 1; k > 0; k--) begin
        t_d[k] = t_q[k-1];
      end
      if (ex_valid_i && !stall_o) begin
        t_d[0] = '{valid: 1'b1, wb: ex_wb_i, load: ex_load_i, rd: RD_W_MAX'(ex_rd_i)};
      end else begin
        t_d[0] = '0;
      end
    end
  end

  // Tracking register; asynchronous reset empties the window at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < NUM_FWD; k++) begin
        t_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_FWD; k++) begin
        t_q[k] <= t_d[k];
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_fwd_q,   perf_fwd_d;

  // Saturating counters, advanced only on cycles the pipeline actually moves.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_fwd_d   = perf_fwd_q;
    if (!hold_i && stall_o && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (!hold_i && (|fwd_sel_o) && (perf_fwd_q != '1)) begin
      perf_fwd_d = perf_fwd_q + 32'd1;
    end
  end

  // Counter registers: cleared by reset only, flush has no effect.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_fwd_q   <= perf_fwd_d;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_fwd_o   = perf_fwd_q;
`endif

endmodule
`default_nettype wire
